fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: StallF / StallD / FlushD  in  1 each  hazard-unit hold-PC / hold-F-D-reg / bubble-D.
REQ-004 SHALL have ports: BranchTakenD  in  1, ALUResultE  in  32  early-branch redirect and its target.
REQ-005 SHALL have ports: PCSrcW  in  1, ResultW  in  32  writeback PC-write redirect and its target.
REQ-006 SHALL have ports: IAddrF  out  32, IReqF  out  1, IRdataF  in  32, IAckF  in  1  instruction-memory request/ack.
REQ-007 SHALL have ports: InstrD  out  32, PCPlus8D  out  32, InstrValidD  out  1  decode-stage instruction, its PC+8, valid.
REQ-008 SHALL have ports: FetchBusyF  out  1  high while a request is outstanding without ack.

Function
REQ-009 SHALL hold PCF (32b), PendPC (32b), HoldInstr/HoldPC (32b each), and FSM states FETCH, DISCARD, HOLD.
REQ-010 SHALL drive IAddrF=PCF; IReqF=1 in FETCH and DISCARD, 0 in HOLD; FetchBusyF=IReqF&~IAckF.
REQ-011 Memory rule: IAddrF stable while IReqF=1 until IAckF=1; IRdataF valid only in the ack cycle; same-cycle ack legal.
REQ-012 Redirect=BranchTakenD|PCSrcW; target=BranchTakenD ? ALUResultE : ResultW (BranchTakenD wins); redirect overrides StallF.
REQ-013 FETCH, ack, no redirect, ~StallF: PCF<=PCF+4 (mod 2^32, 0xFFFFFFFC wraps to 0).
REQ-014 FETCH, ack, ~StallD, ~FlushD: InstrD<=IRdataF, PCPlus8D<=PCF+8, InstrValidD<=1 next edge.
REQ-015 FETCH, ack, StallD: HoldInstr<=IRdataF, HoldPC<=PCF+8, go HOLD; D register unchanged.
REQ-016 FETCH, no ack, ~StallD: D register loads bubble (InstrD=0, InstrValidD=0).
REQ-017 FETCH, redirect, ack same cycle: PCF<=target, stay FETCH, fetched word dropped, D loads bubble.
REQ-018 FETCH, redirect, no ack: PendPC<=target, go DISCARD; PCF unchanged.
REQ-019 DISCARD: further redirect overwrites PendPC; on ack PCF<=PendPC (or new target if redirect same cycle), data dropped, go FETCH.
REQ-020 HOLD, ~StallD: InstrD<=HoldInstr, PCPlus8D<=HoldPC, InstrValidD<=1, go FETCH.
REQ-021 HOLD, redirect: hold buffer dropped, PCF<=target, go FETCH; D loads bubble unless StallD.
REQ-022 FlushD (~StallD) SHALL load bubble into D and, in HOLD, drop buffer and go FETCH; FlushD beats StallD.
REQ-023 StallD with no FlushD SHALL keep InstrD, PCPlus8D, InstrValidD unchanged.

Reset
REQ-024 reset=0 SHALL asynchronously set PCF=0, PendPC=0, hold regs=0, state FETCH, InstrD=0, PCPlus8D=0, InstrValidD=0.
REQ-025 Reset mid-request SHALL abandon it; first request after release SHALL be IAddrF=0, IReqF=1.

Configuration
REQ-026 FETCH_STATS_EN defined: add output FetchStallCntF (16b), +1 (saturate 0xFFFF) each cycle FetchBusyF=1 or state DISCARD; reset 0.
REQ-027 FETCH_STATS_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-028 Zero-wait memory (IAckF tied 1), no stalls: release reset -> IAddrF 0,4,8,...; InstrD word@0 valid 1 cycle later, PCPlus8D=8.
REQ-029 IAckF low 3 cycles at PC=0x10 -> PCF held 0x10, FetchBusyF=1 three cycles, InstrValidD=0 those cycles.
REQ-030 BranchTakenD=1, ALUResultE=0x100 while ack pending at 0x20 -> DISCARD; after ack IAddrF=0x100; word@0x20 never in InstrD.
REQ-031 BranchTakenD=1 (0x40) with PCSrcW=1 (0x80) same cycle -> next IAddrF=0x40.
REQ-032 StallD=1 two cycles during ack at 0x30 -> HOLD, IReqF=0; on release InstrD=word@0x30, PCPlus8D=0x38.
REQ-033 reset=0 asserted mid-DISCARD -> immediately PCF=0, InstrValidD=0; after release IAddrF=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IMEM request/ack handshake, redirect handling and F/D pipeline register.
// Optional FetchStallCntF statistics output is enabled by defining FETCH_STATS_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenD,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] IAddrF,
    output logic        IReqF,
    input  logic [31:0] IRdataF,
    input  logic        IAckF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        InstrValidD,
    output logic        FetchBusyF
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] FetchStallCntF
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pcf,        w_pcf_next;
    logic [31:0] r_pend_pc,    w_pend_pc_next;
    logic [31:0] r_hold_instr, w_hold_instr_next;
    logic [31:0] r_hold_pc,    w_hold_pc_next;
    logic [31:0] r_instr_d,    w_instr_d_next;
    logic [31:0] r_pc8_d,      w_pc8_d_next;
    logic        r_valid_d,    w_valid_d_next;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic        w_d_hold;
    logic [31:0] w_cand_instr;
    logic [31:0] w_cand_pc8;
    logic        w_cand_valid;

    // The branch resolved in decode is younger than the writeback redirect, so it wins.
    assign w_redirect = BranchTakenD | PCSrcW;
    assign w_target   = BranchTakenD ? ALUResultE : ResultW;
    assign w_pc_plus4 = r_pcf + 32'd4;
    assign w_pc_plus8 = r_pcf + 32'd8;
    assign w_d_hold   = StallD & ~FlushD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_redirect && !IAckF) begin
                    w_state_next = S_DISCARD;
                end else if (!w_redirect && IAckF && w_d_hold) begin
                    w_state_next = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (IAckF) begin
                    w_state_next = S_FETCH;
                end
            end
            S_HOLD: begin
                if (w_redirect || !w_d_hold) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        IAddrF     = r_pcf;
        IReqF      = (r_state != S_HOLD);
        FetchBusyF = IReqF & ~IAckF;
    end

    // Datapath next values; the D register defaults to a bubble unless a word is delivered.
    always_comb begin
        w_pcf_next        = r_pcf;
        w_pend_pc_next    = r_pend_pc;
        w_hold_instr_next = r_hold_instr;
        w_hold_pc_next    = r_hold_pc;
        w_cand_instr      = 32'd0;
        w_cand_pc8        = 32'd0;
        w_cand_valid      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_redirect) begin
                    if (IAckF) begin
                        w_pcf_next = w_target;
                    end else begin
                        w_pend_pc_next = w_target;
                    end
                end else if (IAckF) begin
                    if (!StallF) begin
                        w_pcf_next = w_pc_plus4;
                    end
                    if (w_d_hold) begin
                        w_hold_instr_next = IRdataF;
                        w_hold_pc_next    = w_pc_plus8;
                    end else if (!FlushD) begin
                        w_cand_instr = IRdataF;
                        w_cand_pc8   = w_pc_plus8;
                        w_cand_valid = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (w_redirect) begin
                    w_pend_pc_next = w_target;
                end
                if (IAckF) begin
                    w_pcf_next = w_redirect ? w_target : r_pend_pc;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_pcf_next = w_target;
                end else if (!StallD && !FlushD) begin
                    w_cand_instr = r_hold_instr;
                    w_cand_pc8   = r_hold_pc;
                    w_cand_valid = 1'b1;
                end
            end
            default: begin
                w_pcf_next = r_pcf;
            end
        endcase
        w_instr_d_next = w_d_hold ? r_instr_d : w_cand_instr;
        w_pc8_d_next   = w_d_hold ? r_pc8_d   : w_cand_pc8;
        w_valid_d_next = w_d_hold ? r_valid_d : w_cand_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcf        <= 32'd0;
            r_pend_pc    <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_instr_d    <= 32'd0;
            r_pc8_d      <= 32'd0;
            r_valid_d    <= 1'b0;
        end else begin
            r_pcf        <= w_pcf_next;
            r_pend_pc    <= w_pend_pc_next;
            r_hold_instr <= w_hold_instr_next;
            r_hold_pc    <= w_hold_pc_next;
            r_instr_d    <= w_instr_d_next;
            r_pc8_d      <= w_pc8_d_next;
            r_valid_d    <= w_valid_d_next;
        end
    end

    assign InstrD      = r_instr_d;
    assign PCPlus8D    = r_pc8_d;
    assign InstrValidD = r_valid_d;

`ifdef FETCH_STATS_EN
    logic [15:0] r_stall_cnt;

    // Counts cycles lost to memory wait or to draining a redirected request; saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if ((FetchBusyF || (r_state == S_DISCARD)) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign FetchStallCntF = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then randomized
// stimulus compared every cycle against a queue-based reference model (FETCH_STATS_EN adds the counter).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        BranchTakenD = 1'b0, PCSrcW = 1'b0;
    logic [31:0] ALUResultE = 32'd0, ResultW = 32'd0;
    logic [31:0] IAddrF, IRdataF, InstrD, PCPlus8D;
    logic        IReqF, IAckF, InstrValidD, FetchBusyF;
    logic        tb_ack = 1'b0;
    logic [31:0] tb_junk = 32'hBAD0_BAD0;
`ifdef FETCH_STATS_EN
    logic [15:0] FetchStallCntF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: data is only meaningful in the ack cycle.
    assign IAckF   = tb_ack;
    assign IRdataF = IAckF ? mem_word(IAddrF) : tb_junk;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenD(BranchTakenD), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .IAddrF(IAddrF), .IReqF(IReqF), .IRdataF(IRdataF), .IAckF(IAckF),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .InstrValidD(InstrValidD),
        .FetchBusyF(FetchBusyF)
`ifdef FETCH_STATS_EN
        , .FetchStallCntF(FetchStallCntF)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program counter, an optional pending redirect, a hold queue and the D slot.
    logic [31:0] m_pc = 32'd0;
    bit          m_disc = 1'b0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_hq_instr[$];
    logic [31:0] m_hq_pc8[$];
    logic [31:0] m_instr = 32'd0, m_pc8 = 32'd0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;

    task automatic model_reset();
        m_pc = 32'd0; m_disc = 1'b0; m_pend = 32'd0;
        m_hq_instr.delete(); m_hq_pc8.delete();
        m_instr = 32'd0; m_pc8 = 32'd0; m_valid = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit          redir, holding, busy;
        logic [31:0] tgt, n_instr, n_pc8;
        logic        n_valid;
        redir   = BranchTakenD || PCSrcW;
        tgt     = BranchTakenD ? ALUResultE : ResultW;
        holding = (m_hq_instr.size() != 0);
        busy    = (!holding && !IAckF) || m_disc;
        n_instr = 32'd0; n_pc8 = 32'd0; n_valid = 1'b0;
        if (holding) begin
            if (redir) begin
                m_hq_instr.delete(); m_hq_pc8.delete(); m_pc = tgt;
            end else if (FlushD) begin
                m_hq_instr.delete(); m_hq_pc8.delete();
            end else if (!StallD) begin
                n_instr = m_hq_instr.pop_front(); n_pc8 = m_hq_pc8.pop_front(); n_valid = 1'b1;
            end
        end else if (m_disc) begin
            if (redir) m_pend = tgt;
            if (IAckF) begin
                m_pc = m_pend; m_disc = 1'b0;
            end
        end else if (redir) begin
            if (IAckF) m_pc = tgt;
            else begin
                m_pend = tgt; m_disc = 1'b1;
            end
        end else if (IAckF) begin
            if (StallD && !FlushD) begin
                m_hq_instr.push_back(mem_word(m_pc)); m_hq_pc8.push_back(m_pc + 32'd8);
            end else if (!FlushD) begin
                n_instr = mem_word(m_pc); n_pc8 = m_pc + 32'd8; n_valid = 1'b1;
            end
            if (!StallF) m_pc = m_pc + 32'd4;
        end
        if (!(StallD && !FlushD)) begin
            m_instr = n_instr; m_pc8 = n_pc8; m_valid = n_valid;
        end
        if (busy && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_addr",  IAddrF,      m_pc);
            check("m_req",   {31'd0, IReqF}, {31'd0, (m_hq_instr.size() == 0)});
            check("m_busy",  {31'd0, FetchBusyF}, {31'd0, (m_hq_instr.size() == 0) && !IAckF});
            check("m_instr", InstrD,      m_instr);
            check("m_pc8",   PCPlus8D,    m_pc8);
            check("m_valid", {31'd0, InstrValidD}, {31'd0, m_valid});
`ifdef FETCH_STATS_EN
            check("m_cnt",   {16'd0, FetchStallCntF}, m_cnt);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        int rst_left;
        tb_ack = 1'b1;
        repeat (3) @(negedge clk);
        lit("rst_addr", IAddrF, 32'h0);
        lit("rst_req", {31'd0, IReqF}, 32'h1);
        lit("rst_valid", {31'd0, InstrValidD}, 32'h0);
        lit("rst_instr", InstrD, 32'h0);

        // Zero-wait streaming from address 0
        cyc(); reset = 1'b1;
        @(negedge clk); lit("z_addr0", IAddrF, 32'h0);
        cyc(); @(negedge clk);
        lit("z_addr1", IAddrF, 32'h4);
        lit("z_instr0", InstrD, 32'hC0DE_0000);
        lit("z_pc8_0", PCPlus8D, 32'h8);
        lit("z_valid0", {31'd0, InstrValidD}, 32'h1);
        cyc(); cyc(); cyc();

        // Three wait cycles at 0x10
        tb_ack = 1'b0;
        @(negedge clk); lit("w_addr", IAddrF, 32'h10); lit("w_busy", {31'd0, FetchBusyF}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            cyc(); @(negedge clk);
            lit("w_addr_h", IAddrF, 32'h10);
            lit("w_busy_h", {31'd0, FetchBusyF}, 32'h1);
            lit("w_valid_h", {31'd0, InstrValidD}, 32'h0);
        end
        cyc(); tb_ack = 1'b1;
        @(negedge clk); lit("w_busy_end", {31'd0, FetchBusyF}, 32'h0);
        cyc(); @(negedge clk);
        lit("w_addr_next", IAddrF, 32'h14);
        lit("w_instr", InstrD, 32'hC0DE_0010);

        // Branch while the request at 0x20 is unacknowledged
        cyc(); cyc(); cyc();
        tb_ack = 1'b0; BranchTakenD = 1'b1; ALUResultE = 32'h100;
        @(negedge clk); lit("d_addr", IAddrF, 32'h20);
        cyc(); BranchTakenD = 1'b0;
        @(negedge clk); lit("d_addr_stable", IAddrF, 32'h20); lit("d_req", {31'd0, IReqF}, 32'h1);
        cyc(); tb_ack = 1'b1;
        cyc(); @(negedge clk);
        lit("d_addr_tgt", IAddrF, 32'h100);
        lit("d_valid", {31'd0, InstrValidD}, 32'h0);

        // Simultaneous branch and writeback redirect
        cyc(); BranchTakenD = 1'b1; ALUResultE = 32'h40; PCSrcW = 1'b1; ResultW = 32'h80;
        @(negedge clk); lit("d_instr_tgt", InstrD, 32'hC0DE_0100);
        cyc(); BranchTakenD = 1'b0; ResultW = 32'h30;
        @(negedge clk); lit("p_addr", IAddrF, 32'h40);

        // Decode stall during the ack at 0x30
        cyc(); PCSrcW = 1'b0; StallD = 1'b1;
        @(negedge clk); lit("h_addr", IAddrF, 32'h30);
        cyc(); @(negedge clk); lit("h_req0", {31'd0, IReqF}, 32'h0);
        cyc(); StallD = 1'b0;
        @(negedge clk); lit("h_req1", {31'd0, IReqF}, 32'h0);
        cyc(); tb_ack = 1'b0; BranchTakenD = 1'b1; ALUResultE = 32'h200;
        @(negedge clk);
        lit("h_instr", InstrD, 32'hC0DE_0030);
        lit("h_pc8", PCPlus8D, 32'h38);
        lit("h_valid", {31'd0, InstrValidD}, 32'h1);

        // Reset while draining a redirected request
        cyc(); BranchTakenD = 1'b0;
        cyc(); reset = 1'b0;
        #1; lit("r_addr", IAddrF, 32'h0); lit("r_valid", {31'd0, InstrValidD}, 32'h0);
        cyc(); reset = 1'b1; tb_ack = 1'b1;
        @(negedge clk); lit("r_addr_rel", IAddrF, 32'h0); lit("r_req_rel", {31'd0, IReqF}, 32'h1);

        // Randomized traffic
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0; rst_left = 2;
            end
            tb_junk      = $urandom;
            tb_ack       = ($urandom_range(0, 9) < 6) && IReqF;
            StallD       = ($urandom_range(0, 4) == 0);
            StallF       = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : StallD;
            FlushD       = ($urandom_range(0, 9) == 0);
            BranchTakenD = ($urandom_range(0, 11) == 0);
            PCSrcW       = ($urandom_range(0, 15) == 0);
            ALUResultE   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            ResultW      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        end
        cyc();
        reset = 1'b1; tb_ack = 1'b0; StallD = 1'b0; StallF = 1'b0; FlushD = 1'b0;
        BranchTakenD = 1'b0; PCSrcW = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
